// File: rtl/div_pkg.sv
// Shared widths, operation encodings, FSM states and sign helpers for the divider.
package div_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_SIGN = 2'b10,
      S_DONE = 2'b11
   } div_state_e;

   // DIV and REM interpret their operands as two's complement.
   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   // REM and REMU return the remainder; the others return the quotient.
   function automatic logic op_is_rem(input logic [1:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   // Two's complement negation when neg is set, pass-through otherwise.
   function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
      if (neg) begin
         return {XLEN{1'b0}} - v;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, try to subtract the divisor.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] divisor,
   input  logic            dividend_bit,
   output logic [XLEN-1:0] rem_out,
   output logic            quo_bit
);

   logic [XLEN:0] trial_s;

   // The partial remainder is always below the divisor, so bit XLEN of the trial is the borrow.
   always_comb begin
      trial_s = {rem_in, dividend_bit} - {1'b0, divisor};
      quo_bit = ~trial_s[XLEN];
      if (quo_bit) begin
         rem_out = trial_s[XLEN-1:0];
      end else begin
         rem_out = {rem_in[XLEN-2:0], dividend_bit};
      end
   end

endmodule

// File: rtl/divider.sv
// Iterative 32-bit divider: DIV/DIVU/REM/REMU, one quotient bit per cycle,
// divide-by-zero and signed overflow resolved on accept.
module divider #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] data_a_i,
   input  logic [XLEN-1:0] data_b_i,
   output logic            valid_o,
   output logic [XLEN-1:0] data_o
);
   import div_pkg::*;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e       state_r, state_nxt;
   logic [1:0]       op_r;
   logic             neg_q_r, neg_rem_r;
   logic [XLEN-1:0]  rem_r, quo_r, dvs_r;
   logic [CNT_W-1:0] count_r;
   logic             ready_r, valid_r;
   logic [XLEN-1:0]  data_r;

   logic             accept_s, sgn_in_s, zero_s, ovf_s, special_s;
   logic [XLEN-1:0]  special_data_s, result_s, step_rem_s;
   logic             step_q_s;

   div_step #(.XLEN(XLEN)) u_step (
      .rem_in       (rem_r),
      .divisor      (dvs_r),
      .dividend_bit (quo_r[XLEN-1]),
      .rem_out      (step_rem_s),
      .quo_bit      (step_q_s)
   );

   // Classify the incoming request; zero divisor and INT_MIN/-1 skip the iterations.
   always_comb begin
      sgn_in_s  = op_is_signed(op_i);
      zero_s    = (data_b_i == {XLEN{1'b0}});
      ovf_s     = sgn_in_s && (data_a_i == INT_MIN) && (data_b_i == {XLEN{1'b1}});
      special_s = zero_s || ovf_s;
      if (zero_s) begin
         special_data_s = op_is_rem(op_i) ? data_a_i : {XLEN{1'b1}};
      end else if (op_is_rem(op_i)) begin
         special_data_s = {XLEN{1'b0}};
      end else begin
         special_data_s = INT_MIN;
      end
   end

   // Restore signs on the unsigned quotient/remainder (negating zero stays zero).
   always_comb begin
      if (op_is_rem(op_r)) begin
         result_s = cond_neg(neg_rem_r, rem_r);
      end else begin
         result_s = cond_neg(neg_q_r, quo_r);
      end
   end

   // Next-state logic: accept only in IDLE, 32 CALC cycles, then SIGN and DONE.
   always_comb begin
      state_nxt = state_r;
      accept_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (valid_i) begin
               accept_s  = 1'b1;
               state_nxt = special_s ? S_DONE : S_CALC;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_CALC: begin
            if (count_r == CNT_W'(XLEN - 1)) begin
               state_nxt = S_SIGN;
            end else begin
               state_nxt = S_CALC;
            end
         end
         S_SIGN:  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Working registers: capture magnitudes on accept, then shift one quotient bit in per CALC cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_r      <= 2'b00;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         rem_r     <= {XLEN{1'b0}};
         quo_r     <= {XLEN{1'b0}};
         dvs_r     <= {XLEN{1'b0}};
         count_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  op_r      <= op_i;
                  neg_q_r   <= sgn_in_s & (data_a_i[XLEN-1] ^ data_b_i[XLEN-1]);
                  neg_rem_r <= sgn_in_s & data_a_i[XLEN-1];
                  rem_r     <= {XLEN{1'b0}};
                  quo_r     <= cond_neg(sgn_in_s & data_a_i[XLEN-1], data_a_i);
                  dvs_r     <= cond_neg(sgn_in_s & data_b_i[XLEN-1], data_b_i);
                  count_r   <= {CNT_W{1'b0}};
               end
            end
            S_CALC: begin
               rem_r   <= step_rem_s;
               quo_r   <= {quo_r[XLEN-2:0], step_q_s};
               count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: begin
            end
         endcase
      end
   end

   // Registered outputs: ready tracks IDLE, valid pulses for the DONE cycle, data holds until next result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ready_r <= 1'b1;
         valid_r <= 1'b0;
         data_r  <= {XLEN{1'b0}};
      end else begin
         ready_r <= (state_nxt == S_IDLE);
         valid_r <= (state_nxt == S_DONE);
         if (accept_s && special_s) begin
            data_r <= special_data_s;
         end else if (state_r == S_SIGN) begin
            data_r <= result_s;
         end
      end
   end

   assign ready_o = ready_r;
   assign valid_o = valid_r;
   assign data_o  = data_r;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed corner cases, random ops,
// reset abort and continuous-request behaviour against a plain arithmetic model.
module tb_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic        ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        valid_out;
   logic [31:0] data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   divider #(.XLEN(32)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .valid_i  (valid_in),
      .ready_o  (ready),
      .op_i     (op),
      .data_a_i (a),
      .data_b_i (b),
      .valid_o  (valid_out),
      .data_o   (data)
   );

   // Reference result from the arithmetic definition of each operation.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic is_signed, is_rem;
      is_signed = (o == 2'b00) || (o == 2'b10);
      is_rem    = (o == 2'b10) || (o == 2'b11);
      if (y == 32'd0) return is_rem ? x : 32'hFFFF_FFFF;
      if (is_signed && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
      if (is_signed) return is_rem ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
      return is_rem ? (x % y) : (x / y);
   endfunction

   // Cycles from accept edge to the valid_o cycle.
   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic is_signed;
      is_signed = (o == 2'b00) || (o == 2'b10);
      if (y == 32'd0) return 1;
      if (is_signed && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   task automatic rand_operands(output logic [1:0] o, output logic [31:0] x, output logic [31:0] y);
      int kind;
      o    = 2'($urandom_range(0, 3));
      x    = $urandom;
      kind = $urandom_range(0, 5);
      case (kind)
         0: y = 32'd0;
         1: y = 32'($urandom_range(1, 15));
         2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
         3: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
         default: y = $urandom;
      endcase
   endtask

   task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] exp_d, got;
      int exp_l, lat;
      exp_d = ref_result(o, x, y);
      exp_l = ref_lat(o, x, y);
      @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b expected 1", name, ready);
      end
      valid_in = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      lat = 0; got = 32'd0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         valid_in = 1'b0;
         if (valid_out === 1'b1) begin
            lat = i; got = data;
            break;
         end
      end
      checks++;
      if (lat != exp_l) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d (op=%b a=%h b=%h)", name, lat, exp_l, o, x, y);
      end
      checks++;
      if (got !== exp_d) begin
         errors++;
         $display("FAIL %s data: got %h expected %h (op=%b a=%h b=%h)", name, got, exp_d, o, x, y);
      end
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || data !== exp_d) begin
         errors++;
         $display("FAIL %s pulse_hold: valid=%b data=%h expected valid=0 data=%h", name, valid_out, data, exp_d);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; valid_in = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || valid_out !== 1'b0 || data !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: ready=%b valid=%b data=%h expected 1 0 00000000", ready, valid_out, data);
      end
      valid_in = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b valid=%b expected 1 0", ready, valid_out);
      end
   endtask

   task automatic test_directed();
      check_op("divu_100_7",   2'b01, 32'd100,        32'd7);
      check_op("remu_100_7",   2'b11, 32'd100,        32'd7);
      check_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2);
      check_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2);
      check_op("rem_7_m2",     2'b10, 32'd7,          32'hFFFF_FFFE);
      check_op("div_5_0",      2'b00, 32'd5,          32'd0);
      check_op("remu_5_0",     2'b11, 32'd5,          32'd0);
      check_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF);
      check_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF);
      check_op("divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1);
      check_op("div_min_1",    2'b00, 32'h8000_0000,  32'd1);
      check_op("divu_ovfpat",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF);
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] x, y;
      for (int n = 0; n < 40; n++) begin
         rand_operands(o, x, y);
         check_op("random", o, x, y);
      end
   endtask

   task automatic test_reset_abort();
      logic seen;
      @(negedge clk);
      valid_in = 1'b1; op = 2'b01; a = 32'd1_000_000; b = 32'd37;
      @(posedge clk);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || data !== 32'd0) begin
         errors++;
         $display("FAIL abort_reset_clear: valid=%b data=%h expected 0 00000000", valid_out, data);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready: got %b expected 1", ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (valid_out !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_valid: got valid pulse expected none");
      end
      check_op("after_abort_divu_9_3", 2'b01, 32'd9, 32'd3);
   endtask

   // valid_i held high with new operands every cycle; the model tracks the busy window per accept.
   task automatic test_back_to_back();
      int          busy, captures, results;
      logic [31:0] cur_exp;
      logic [1:0]  o;
      logic [31:0] x, y;
      logic        active;
      busy = 0; captures = 0; results = 0; cur_exp = 32'd0;
      @(negedge clk);
      for (int cyc = 0; cyc < 400; cyc++) begin
         checks++;
         if (ready !== (busy == 0)) begin
            errors++;
            $display("FAIL b2b_ready cycle %0d: got %b expected %b", cyc, ready, (busy == 0));
         end
         checks++;
         if (busy == 1) begin
            results++;
            if (valid_out !== 1'b1 || data !== cur_exp) begin
               errors++;
               $display("FAIL b2b_result cycle %0d: valid=%b data=%h expected 1 %h", cyc, valid_out, data, cur_exp);
            end
         end else if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid cycle %0d: got %b expected 0", cyc, valid_out);
         end
         rand_operands(o, x, y);
         active = (cyc < 300);
         valid_in = active; op = o; a = x; b = y;
         @(posedge clk);
         if (busy == 0) begin
            if (active) begin
               cur_exp = ref_result(o, x, y);
               busy    = ref_lat(o, x, y);
               captures++;
            end
         end else begin
            busy--;
         end
         @(negedge clk);
      end
      valid_in = 1'b0;
      checks++;
      if (results != captures || captures < 8) begin
         errors++;
         $display("FAIL b2b_count: results=%0d captures=%0d expected equal and at least 8", results, captures);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
